dot_accumulator: RTL and testbench
==================================

// Module: dot_accumulator
// PURPOSE
//  Downstream consumer of the combinational signed Multiplier: takes its 2*INPUTSIZE-bit
//  two's-complement product z, one product per handshake. Accumulates TERMS products into a
//  saturating signed dot-product, then holds the result on a valid/ready output until taken.
//  Forms the MAC back end; the Multiplier's operand pairs are presented in lockstep upstream.
// PARAMETERS
//  INPUTSIZE  4                 multiplier operand width; product width = 2*INPUTSIZE
//  TERMS      4                 products per dot-product (>=2)
//  ACCSIZE    2*INPUTSIZE+2     accumulator width, signed; must be >= 2*INPUTSIZE
// PORTS
//  clk        in   1            single clock, rising edge
//  rst        in   1            asynchronous, active-high reset
//  in_valid   in   1            prod is valid this cycle
//  in_ready   out  1            block can accept a product
//  prod       in   2*INPUTSIZE  signed product (Multiplier z)
//  out_valid  out  1            acc holds a completed dot-product
//  out_ready  in   1            consumer takes result
//  acc        out  ACCSIZE      signed accumulated result (registered)
//  ovf        out  1            sticky: saturation occurred in the current dot-product
//  ZF         out  1            out_valid && (acc == 0)
// BEHAVIOUR
//  - Reset (async, any time incl. mid-operation): state=ACC, count=0, acc=0, ovf=0,
//    out_valid=0; in_ready=1 from the first clock after release. Partial sums are discarded.
//  - States: ACC (collecting), HOLD (result presented). No other states.
//  - in_ready = (state==ACC); out_valid = (state==HOLD). Both purely state-decoded.
//  - Accept = in_valid && in_ready. Only accepted cycles change acc/count; in_valid in HOLD
//    is ignored (no accept, no storage).
//  - On accept: s = sext(acc,ACCSIZE+1) + sext(prod,ACCSIZE+1). If s > 2^(ACCSIZE-1)-1 then
//    acc <= 2^(ACCSIZE-1)-1, ovf <= 1; if s < -2^(ACCSIZE-1) then acc <= -2^(ACCSIZE-1),
//    ovf <= 1; else acc <= s[ACCSIZE-1:0]. Clamp is per step; later terms continue from
//    the clamped value. ovf never clears within a dot-product.
//  - count increments per accept; on the accept where count==TERMS-1: count<=0, state<=HOLD.
//  - Latency: out_valid rises the cycle after the TERMS-th accept; back-to-back input gives
//    one result every TERMS+1 cycles minimum (one bubble cycle in HOLD).
//  - HOLD: acc, ovf, ZF stable while out_ready=0, indefinitely.
//  - out_valid && out_ready: next cycle state=ACC, acc=0, ovf=0, count=0, in_ready=1.
//    No input is accepted in the handoff cycle itself (in_ready is 0 in HOLD).
//  - acc is visible during ACC as the running partial sum but is meaningful only when
//    out_valid=1; ZF is forced 0 outside HOLD.
// STRUCTURE
//  - Shared header dot_defs.vh (`ifndef-guarded): state encodings ST_ACC/ST_HOLD,
//    count width macro CLOG2-based for TERMS.
//  - One sub-module: sat_add #(IN_W, ACC_W) -- combinational sign-extend, add, clamp,
//    emits sum and sat flag. Top holds FSM, counter, acc/ovf registers.
// TESTING (INPUTSIZE=4, TERMS=4 unless stated)
//  1 Reset: assert rst mid-run -> immediately out_valid=0, acc=0, ovf=0; in_ready=1 after release.
//  2 prod 6,-3,10,0 back-to-back -> 1 cycle after 4th accept out_valid=1, acc=13, ovf=0, ZF=0, in_ready=0.
//  3 Hold out_ready=0 for 5 cycles with in_valid=1, prod=7 -> acc stays 13, no accept;
//    out_ready=1 -> next cycle out_valid=0, in_ready=1, acc=0.
//  4 prod 5,-5,3,-3 -> acc=0, ZF=1, ovf=0.
//  5 ACCSIZE=8: prod 64,64,-10,0 -> 64+64 clamps to 127, then 117; final acc=117, ovf=1;
//    prod -64,-64,-64,0 -> acc=-128, ovf=1; ovf cleared after handoff.
//  6 in_valid toggling 1,0,1,0,... with prod 2 each valid cycle -> result acc=8 only after 4
//    accepted beats; reset after 2 accepts then 4 fresh beats of 1 -> acc=4 (no carry-over).

Source files
------------

// File: rtl/dot_accumulator_pkg.sv
// Shared types and helpers for the dot-product accumulator back end.
// Holds the collect/present state encoding and the counter width helper.
package dot_accumulator_pkg;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Counter width for TERMS products; a single-bit counter is the floor.
    function automatic int count_width(input int terms);
        return (terms > 1) ? $clog2(terms) : 1;
    endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational saturating signed add: acc + sext(addend), clamped to ACC_W bits.
// sat flags that the clamp was applied on this step.
module sat_add #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 10
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [IN_W-1:0]  addend,
    output logic [ACC_W-1:0] sum,
    output logic             sat
);

    logic [ACC_W:0] acc_ext;
    logic [ACC_W:0] add_ext;
    logic [ACC_W:0] s;

    assign acc_ext = {acc[ACC_W-1], acc};
    assign add_ext = {{(ACC_W + 1 - IN_W){addend[IN_W-1]}}, addend};
    assign s       = acc_ext + add_ext;

    // One guard bit holds the exact sum; disagreement with the sign bit means out of range.
    always_comb begin
        sat = (s[ACC_W] != s[ACC_W-1]);
        sum = s[ACC_W-1:0];
        if (sat) begin
            sum = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/dot_accumulator.sv
// MAC back end: accumulates TERMS signed products into a saturating dot-product and
// presents it on a valid/ready output until taken.
module dot_accumulator
    import dot_accumulator_pkg::*;
#(
    parameter int INPUTSIZE = 4,
    parameter int TERMS     = 4,
    parameter int ACCSIZE   = 2 * INPUTSIZE + 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2*INPUTSIZE-1:0] prod,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACCSIZE-1:0]     acc,
    output logic                   ovf,
    output logic                   ZF
);

    localparam int PROD_W = 2 * INPUTSIZE;
    localparam int CNT_W  = count_width(TERMS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TERMS - 1);

    // Handshake: a beat transfers on a cycle where valid and ready are both high;
    // ready never depends on valid, and both sides are decoded purely from state.
    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [ACCSIZE-1:0] next_sum;
    logic               next_sat;

    sat_add #(
        .IN_W  (PROD_W),
        .ACC_W (ACCSIZE)
    ) u_sat_add (
        .acc    (acc),
        .addend (prod),
        .sum    (next_sum),
        .sat    (next_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_ACC;
            count <= '0;
            acc   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (in_valid) begin
                        acc <= next_sum;
                        if (next_sat) ovf <= 1'b1;
                        if (count == LAST) begin
                            count <= '0;
                            state <= ST_HOLD;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state <= ST_ACC;
                        count <= '0;
                        acc   <= '0;
                        ovf   <= 1'b0;
                    end
                end
                default: state <= ST_ACC;
            endcase
        end
    end

    assign in_ready  = (state == ST_ACC);
    assign out_valid = (state == ST_HOLD);
    assign ZF        = out_valid && (acc == '0);

endmodule

// File: tb/tb_dot_accumulator.sv
// Bench for dot_accumulator: two instances (ACCSIZE 10 and 8) share stimulus, each with
// its own saturating reference model and expected-result queue.
module tb_dot_accumulator;

    localparam int IW    = 4;
    localparam int TERMS = 4;
    localparam int PW    = 2 * IW;
    localparam int AW_A  = 2 * IW + 2;
    localparam int AW_B  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          out_ready;
    logic [PW-1:0] prod;

    logic            in_ready_a, out_valid_a, ovf_a, zf_a;
    logic [AW_A-1:0] acc_a;
    logic            in_ready_b, out_valid_b, ovf_b, zf_b;
    logic [AW_B-1:0] acc_b;

    int n_checks = 0;
    int n_errors = 0;

    logic [AW_A:0] exp_q_a[$];
    logic [AW_B:0] exp_q_b[$];

    int m_acc_a, m_acc_b;
    bit m_ovf_a, m_ovf_b;

    dot_accumulator #(.INPUTSIZE(IW), .TERMS(TERMS), .ACCSIZE(AW_A)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .prod(prod),
        .out_valid(out_valid_a), .out_ready(out_ready), .acc(acc_a), .ovf(ovf_a), .ZF(zf_a)
    );

    dot_accumulator #(.INPUTSIZE(IW), .TERMS(TERMS), .ACCSIZE(AW_B)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .prod(prod),
        .out_valid(out_valid_b), .out_ready(out_ready), .acc(acc_b), .ovf(ovf_b), .ZF(zf_b)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: exact integer sum, clamped to a signed w-bit range.
    function automatic int clamp_add(input int a, input int p, input int w, inout bit o);
        int s, hi, lo;
        s  = a + p;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (s > hi) begin s = hi; o = 1'b1; end
        if (s < lo) begin s = lo; o = 1'b1; end
        return s;
    endfunction

    task automatic model_reset();
        m_acc_a = 0; m_ovf_a = 1'b0;
        m_acc_b = 0; m_ovf_b = 1'b0;
    endtask

    task automatic apply_beat(input int p);
        m_acc_a = clamp_add(m_acc_a, p, AW_A, m_ovf_a);
        m_acc_b = clamp_add(m_acc_b, p, AW_B, m_ovf_b);
    endtask

    // Driver: TERMS beats with `gap` idle cycles before each; optionally keeps in_valid high after.
    task automatic send_vec(input int v0, input int v1, input int v2, input int v3,
                            input int gap, input bit hold_valid, input int hold_prod);
        int v[4];
        v = '{v0, v1, v2, v3};
        for (int i = 0; i < TERMS; i++) begin
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                in_valid = 1'b0;
                prod     = PW'(hold_prod);
            end
            @(negedge clk);
            check("in_ready_a_collect", in_ready_a, 1);
            check("out_valid_a_collect", out_valid_a, 0);
            in_valid = 1'b1;
            prod     = PW'(v[i]);
            apply_beat(v[i]);
        end
        exp_q_a.push_back({m_ovf_a, AW_A'(m_acc_a)});
        exp_q_b.push_back({m_ovf_b, AW_B'(m_acc_b)});
        @(negedge clk);
        in_valid = hold_valid;
        prod     = PW'(hold_prod);
        check("latency_a", out_valid_a, 1);
        check("latency_b", out_valid_b, 1);
    endtask

    // Scoreboard: wait for both results, compare, stall, then hand off.
    task automatic receive(input int stall);
        int waited;
        logic [AW_A:0] ea;
        logic [AW_B:0] eb;
        waited = 0;
        while (!(out_valid_a && out_valid_b) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("out_valid_wait", (waited < 50) ? 1 : 0, 1);
        check("queue_nonempty", ((exp_q_a.size() > 0) && (exp_q_b.size() > 0)) ? 1 : 0, 1);
        ea = (exp_q_a.size() > 0) ? exp_q_a.pop_front() : '0;
        eb = (exp_q_b.size() > 0) ? exp_q_b.pop_front() : '0;
        for (int c = 0; c <= stall; c++) begin
            check("acc_a", $signed(acc_a), $signed(ea[AW_A-1:0]));
            check("ovf_a", ovf_a, ea[AW_A]);
            check("zf_a", zf_a, (ea[AW_A-1:0] == '0) ? 1 : 0);
            check("in_ready_a_hold", in_ready_a, 0);
            check("acc_b", $signed(acc_b), $signed(eb[AW_B-1:0]));
            check("ovf_b", ovf_b, eb[AW_B]);
            check("zf_b", zf_b, (eb[AW_B-1:0] == '0) ? 1 : 0);
            check("out_valid_b_hold", out_valid_b, 1);
            if (c < stall) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        model_reset();
        check("handoff_out_valid_a", out_valid_a, 0);
        check("handoff_in_ready_a", in_ready_a, 1);
        check("handoff_acc_a", $signed(acc_a), 0);
        check("handoff_ovf_a", ovf_a, 0);
        check("handoff_zf_a", zf_a, 0);
        check("handoff_acc_b", $signed(acc_b), 0);
        check("handoff_ovf_b", ovf_b, 0);
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_out_valid_a", out_valid_a, 0);
        check("rst_acc_a", $signed(acc_a), 0);
        check("rst_ovf_a", ovf_a, 0);
        check("rst_acc_b", $signed(acc_b), 0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        model_reset();
        exp_q_a.delete();
        exp_q_b.delete();
        @(negedge clk);
        check("post_rst_in_ready_a", in_ready_a, 1);
        check("post_rst_in_ready_b", in_ready_b, 1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        prod      = '0;
        model_reset();
        #1;
        check("init_acc_a", $signed(acc_a), 0);
        check("init_out_valid_a", out_valid_a, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("init_in_ready_a", in_ready_a, 1);

        // Mid-run reset discards the partial sum
        in_valid = 1'b1; prod = PW'(3);
        @(negedge clk);
        prod = PW'(4);
        @(negedge clk);
        in_valid = 1'b0;
        check("partial_acc_a", $signed(acc_a), 7);
        async_reset();

        // Basic dot-product, then hold with in_valid=1, prod=7 ignored
        send_vec(6, -3, 10, 0, 0, 1'b1, 7);
        receive(5);

        // Zero result
        send_vec(5, -5, 3, -3, 0, 1'b0, 0);
        receive(0);

        // Saturation (clamps in the 8-bit instance)
        send_vec(64, 64, -10, 0, 0, 1'b0, 0);
        receive(1);
        send_vec(-64, -64, -64, 0, 0, 1'b0, 0);
        receive(0);

        // Toggling in_valid
        send_vec(2, 2, 2, 2, 1, 1'b0, 9);
        receive(2);

        // Reset after two accepts, then four fresh beats
        @(negedge clk);
        in_valid = 1'b1; prod = PW'(5);
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        async_reset();
        send_vec(1, 1, 1, 1, 0, 1'b0, 0);
        receive(0);

        // Random products across the full product range
        for (int r = 0; r < 6; r++) begin
            send_vec(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                     int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                     int'($urandom_range(0, 1)), 1'(r % 2), 7);
            receive(int'($urandom_range(0, 3)));
        end

        check("queue_drained", exp_q_a.size() + exp_q_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
